// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request in flight to a variable-latency
// instruction memory, buffers the returned word for IF/ID and handles stall and redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StFull
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] buf_q;
    logic [31:0] pc_out_q;
    logic        drop_q;
    logic [31:0] target;
    logic        unused_tgt_bits;

    assign target          = {branch_target_i[31:2], 2'b00};
    assign unused_tgt_bits = ^branch_target_i[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StReq;
            pc_q     <= {RESET_PC[31:2], 2'b00};
            buf_q    <= 32'h0;
            pc_out_q <= 32'h0;
            drop_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StReq: begin
                    // A redirect suppresses the request, so acceptance cannot happen here.
                    if (branch_i) begin
                        pc_q <= target;
                    end else if (imem_ready_i) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (imem_rvalid_i) begin
                        if (drop_q || branch_i) begin
                            drop_q  <= 1'b0;
                            state_q <= StReq;
                            if (branch_i) begin
                                pc_q <= target;
                            end
                        end else begin
                            buf_q    <= imem_rdata_i;
                            pc_out_q <= pc_q;
                            state_q  <= StFull;
                        end
                    end else if (branch_i) begin
                        // Response still owed by memory; remember to throw it away.
                        pc_q   <= target;
                        drop_q <= 1'b1;
                    end
                end
                StFull: begin
                    if (branch_i) begin
                        pc_q    <= target;
                        state_q <= StReq;
                    end else if (!stall_i) begin
                        pc_q    <= pc_q + 32'd4;
                        state_q <= StReq;
                    end
                end
                default: state_q <= StReq;
            endcase
        end
    end

    assign imem_req_o  = (state_q == StReq) && !branch_i;
    assign imem_addr_o = pc_q;
    assign valid_o     = (state_q == StFull);
    assign instr_o     = (state_q == StFull) ? buf_q : 32'h0;
    assign pc_o        = pc_out_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit: a transaction-level fetch model and a latency-queue
// memory model are checked against the DUT every cycle, plus directed literal scenarios.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .branch_i       (branch_i),
        .branch_target_i(branch_target_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ready_i   (imem_ready_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .valid_o        (valid_o),
        .instr_o        (instr_o),
        .pc_o           (pc_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Stimulus knobs (percent probabilities) and one-shot forces.
    int unsigned p_rst = 0, p_branch = 0, p_stall = 0, p_ready = 100;
    int unsigned lat_min = 1, lat_max = 1;
    logic        f_rst = 1'b0, f_branch = 1'b0, f_data_en = 1'b0;
    logic [31:0] f_tgt = 32'h0, f_data = 32'h0;

    // Memory model: pending responses with remaining cycles before rvalid.
    typedef struct {
        int          cnt;
        logic [31:0] data;
    } resp_t;
    resp_t mq[$];

    // Fetch model: what the stage is doing, expressed as transaction flags.
    logic        m_known = 1'b0;
    logic [31:0] m_pc = 32'h0, m_buf = 32'h0, m_pco = 32'h0;
    logic        m_busy = 1'b0, m_dead = 1'b0, m_have = 1'b0;

    // Snapshot of DUT outputs taken at the check point of the last cycle.
    logic        s_valid, s_req;
    logic [31:0] s_instr, s_pc, s_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        logic        e_req;
        resp_t       r;
        @(negedge clk);
        rst_i           = f_rst || ($urandom_range(99) < p_rst);
        branch_i        = f_branch || ($urandom_range(99) < p_branch);
        branch_target_i = f_branch ? f_tgt : $urandom;
        stall_i         = $urandom_range(99) < p_stall;
        imem_ready_i    = $urandom_range(99) < p_ready;
        imem_rvalid_i   = (mq.size() > 0) && (mq[0].cnt == 0);
        imem_rdata_i    = imem_rvalid_i ? mq[0].data : $urandom;
        f_rst    = 1'b0;
        f_branch = 1'b0;
        #1;
        e_req = !m_busy && !m_have && !branch_i;
        if (m_known) begin
            check("valid_o", {31'b0, valid_o}, {31'b0, m_have});
            check("instr_o", instr_o, m_have ? m_buf : 32'h0);
            check("pc_o", pc_o, m_pco);
            check("imem_req_o", {31'b0, imem_req_o}, {31'b0, e_req});
            check("imem_addr_o", imem_addr_o, m_pc);
        end
        s_valid = valid_o;
        s_req   = imem_req_o;
        s_instr = instr_o;
        s_pc    = pc_o;
        s_addr  = imem_addr_o;
        @(posedge clk);
        // Memory: retire, age, accept.
        if (rst_i) begin
            mq.delete();
        end else begin
            if (imem_rvalid_i) void'(mq.pop_front());
            foreach (mq[i]) if (mq[i].cnt > 0) mq[i].cnt = mq[i].cnt - 1;
            if (m_known && e_req && imem_ready_i) begin
                r.cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
                r.data = f_data_en ? f_data : $urandom;
                mq.push_back(r);
            end
        end
        // Fetch stage model.
        if (rst_i) begin
            m_known = 1'b1;
            m_pc = RESET_PC; m_busy = 1'b0; m_dead = 1'b0;
            m_have = 1'b0; m_buf = 32'h0; m_pco = 32'h0;
        end else if (branch_i) begin
            m_pc   = branch_target_i & 32'hFFFF_FFFC;
            m_have = 1'b0;
            if (m_busy) begin
                if (imem_rvalid_i) begin
                    m_busy = 1'b0;
                    m_dead = 1'b0;
                end else begin
                    m_dead = 1'b1;
                end
            end
        end else if (m_have) begin
            if (!stall_i) begin
                m_have = 1'b0;
                m_pc   = m_pc + 32'd4;
            end
        end else if (m_busy) begin
            if (imem_rvalid_i) begin
                m_busy = 1'b0;
                if (m_dead) begin
                    m_dead = 1'b0;
                end else begin
                    m_have = 1'b1;
                    m_buf  = imem_rdata_i;
                    m_pco  = m_pc;
                end
            end
        end else if (imem_ready_i) begin
            m_busy = 1'b1;
        end
    endtask

    task automatic quiet(input int unsigned lat, input int unsigned stall);
        p_rst = 0; p_branch = 0; p_ready = 100; p_stall = stall;
        lat_min = lat; lat_max = lat;
    endtask

    logic [31:0] addrs[$];
    logic [31:0] pcs[$];
    int          nvalid;
    logic        any_valid;

    initial begin
        // Streaming from reset with wrap-around of the reset PC.
        quiet(1, 0);
        f_rst = 1'b1; cycle();
        nvalid = 0;
        for (int i = 0; i < 9; i++) begin
            cycle();
            if (s_req) addrs.push_back(s_addr);
            if (s_valid) begin
                pcs.push_back(s_pc);
                nvalid++;
                check("stream_valid_slot", i % 3, 2);
            end
        end
        check("stream_nvalid", nvalid, 3);
        check("stream_nreq", addrs.size(), 3);
        if (addrs.size() == 3 && pcs.size() == 3) begin
            check("stream_addr0", addrs[0], 32'hFFFF_FFFC);
            check("stream_addr1", addrs[1], 32'h0000_0000);
            check("stream_addr2", addrs[2], 32'h0000_0004);
            check("stream_pc0", pcs[0], 32'hFFFF_FFFC);
            check("stream_pc2", pcs[2], 32'h0000_0004);
        end

        // Stall holds the buffered instruction.
        quiet(1, 100);
        f_data_en = 1'b1; f_data = 32'hDEAD_BEEF;
        f_rst = 1'b1; cycle();
        cycle(); cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("stall_valid", {31'b0, s_valid}, 32'd1);
            check("stall_instr", s_instr, 32'hDEAD_BEEF);
            check("stall_pc", s_pc, 32'hFFFF_FFFC);
            check("stall_req", {31'b0, s_req}, 32'd0);
        end
        p_stall = 0;
        cycle();
        cycle();
        check("stall_next_req", {31'b0, s_req}, 32'd1);
        check("stall_next_addr", s_addr, 32'h0000_0000);
        f_data_en = 1'b0;

        // Redirect while waiting: stale response discarded.
        quiet(4, 0);
        f_rst = 1'b1; cycle();
        cycle();
        any_valid = 1'b0;
        f_branch = 1'b1; f_tgt = 32'h0000_0103;
        for (int i = 0; i < 4; i++) begin
            cycle();
            any_valid |= s_valid;
        end
        cycle();
        any_valid |= s_valid;
        check("wait_br_no_valid", {31'b0, any_valid}, 32'd0);
        check("wait_br_req", {31'b0, s_req}, 32'd1);
        check("wait_br_addr", s_addr, 32'h0000_0100);

        // Redirect while full and stalled.
        quiet(1, 100);
        f_rst = 1'b1; cycle();
        cycle(); cycle(); cycle();
        f_branch = 1'b1; f_tgt = 32'h0000_0200;
        cycle();
        check("full_br_valid_before", {31'b0, s_valid}, 32'd1);
        cycle();
        check("full_br_valid", {31'b0, s_valid}, 32'd0);
        check("full_br_instr", s_instr, 32'h0);
        check("full_br_req", {31'b0, s_req}, 32'd1);
        check("full_br_addr", s_addr, 32'h0000_0200);

        // Reset while a response is outstanding.
        quiet(4, 0);
        f_rst = 1'b1; cycle();
        cycle();
        p_ready = 0;
        f_rst = 1'b1; cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rst_wait_req", {31'b0, s_req}, 32'd1);
            check("rst_wait_addr", s_addr, 32'hFFFF_FFFC);
            check("rst_wait_valid", {31'b0, s_valid}, 32'd0);
        end
        quiet(1, 0);
        cycle(); cycle(); cycle();
        check("rst_resume_valid", {31'b0, s_valid}, 32'd1);
        check("rst_resume_pc", s_pc, 32'hFFFF_FFFC);

        // Randomised mixes.
        for (int m = 0; m < 4; m++) begin
            p_rst    = (m == 3) ? 2 : 0;
            p_branch = (m == 0) ? 5 : 15;
            p_stall  = (m == 1) ? 60 : 25;
            p_ready  = (m == 2) ? 30 : 70;
            lat_min  = 1;
            lat_max  = (m == 0) ? 2 : 5;
            for (int i = 0; i < 1500; i++) cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues one outstanding request at a time to a variable-latency instruction memory. It buffers the returned word and presents it, with its PC, to IF/ID. It honours the pipeline stall from the hazard unit and redirects on taken branches, discarding any in-flight or buffered wrong-path fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk_i  input  1  single clock; all state updates on posedge.
- rst_i  input  1  synchronous, active-high reset (sampled on posedge clk_i only).
- stall_i  input  1  IF/ID hold (same signal as IF/ID stall); buffered instruction is not consumed while high.
- branch_i  input  1  taken-branch/jump redirect pulse; highest priority after reset.
- branch_target_i  input  32  redirect address; bits [1:0] ignored (forced to 0).
- imem_req_o  output  1  request valid to instruction memory.
- imem_addr_o  output  32  request address (= current PC).
- imem_ready_i  input  1  memory accepts request this cycle when high together with imem_req_o.
- imem_rvalid_i  input  1  response valid; exactly one per accepted request, at least 1 cycle after acceptance.
- imem_rdata_i  input  32  response instruction word.
- valid_o  output  1  instr_o/pc_o hold a live instruction.
- instr_o  output  32  instruction to IF/ID; 32'b0 (bubble) whenever valid_o is 0.
- pc_o  output  32  PC of instr_o; retains last value when valid_o is 0.

## Operation
- State register: S_REQ, S_WAIT, S_FULL. Additional registers: pc, instr buffer, pc_o, drop flag.
- Reset (rst_i=1 at posedge): state=S_REQ, pc=RESET_PC, drop=0, buffer=0, pc_o=0. Consequently valid_o=0, instr_o=0, imem_req_o=1 the cycle after reset is released.
- S_REQ:
  - imem_req_o = !branch_i; imem_addr_o = pc.
  - branch_i: pc<=target, stay S_REQ.
  - Else if imem_ready_i: go to S_WAIT.
  - imem_rvalid_i is ignored in this state.
- S_WAIT:
  - imem_req_o=0.
  - branch_i without rvalid: pc<=target, drop<=1, stay.
  - rvalid with drop=1, or rvalid with branch_i: discard data, drop<=0, pc<=target if branch_i, go to S_REQ.
  - rvalid otherwise: buffer<=rdata, pc_o<=pc, go to S_FULL.
- S_FULL:
  - valid_o=1, instr_o=buffer.
  - branch_i: pc<=target, go to S_REQ; buffer is discarded and never captured.
  - Else if !stall_i: the instruction is consumed by IF/ID this edge; pc<=pc+4, go to S_REQ.
  - Else (stall_i=1): hold state, buffer and pc_o unchanged.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0000_0000. Target is forced to {target[31:2],2'b00}.
- Only one request is outstanding at any time; imem_req_o is never high outside S_REQ.
- Reset mid-operation: any outstanding response is abandoned. The instruction memory shares rst_i and drops its in-flight response.

## Timing
- imem_req_o depends combinationally on branch_i. All other outputs are registered or decoded from state.
- Best-case throughput: ready in S_REQ and rvalid one cycle later give one instruction per 3 cycles.
  - Cycle n: request accepted.
  - Cycle n+1: rvalid.
  - Cycle n+2: valid_o=1.
  - Cycle n+3: next request.
- Redirect to the first request at the target: the request issues in the cycle after branch_i (S_REQ/S_FULL), or in the cycle after the stale response returns (S_WAIT).
- branch_i and stall_i together: branch_i wins.

## Test plan
- Reset release, ready=1, rvalid 1 cycle after acceptance, rdata=32'h0000_0013, stall=0 -> imem_addr_o sequence 0,4,8; valid_o high for exactly one cycle every 3 cycles; pc_o=0,4,8.
- stall_i held 4 cycles while in S_FULL with rdata=32'hDEAD_BEEF -> valid_o, instr_o=32'hDEAD_BEEF and pc_o constant for the whole stall; no imem_req_o; PC advances by 4 only after stall_i drops.
- branch_i with target 32'h0000_0103 in S_WAIT, response arrives 3 cycles later -> response discarded (valid_o stays 0); next request address 32'h0000_0100.
- branch_i in S_FULL with stall_i=1 -> valid_o=0 and instr_o=0 next cycle; next imem_addr_o = target.
- RESET_PC=32'hFFFF_FFFC -> first fetch at FFFF_FFFC, second at 0000_0000.
- rst_i asserted during S_WAIT, memory ready held low 5 cycles -> after reset imem_req_o=1 with addr=RESET_PC; valid_o=0 until the new response returns.
